// File: rtl/block_cell_fetch_if.sv
// Pixel, write-port and output bundle for block_cell_fetch.
// GRID_ON exists only when GRID_LINE_EN is defined.
interface block_cell_fetch_if #(
    parameter int COLOR_W = 3
);
    logic [9:0]         PIX_X;
    logic [9:0]         PIX_Y;
    logic               VIDEO_ON;
    logic               HS_IN;
    logic               VS_IN;
    logic               WE;
    logic [3:0]         W_COL;
    logic [4:0]         W_ROW;
    logic               W_OCC;
    logic [COLOR_W-1:0] W_COLOR;
    logic               CLR;
    logic               BUSY;
    logic [COLOR_W-1:0] COLOR;
    logic               BLOCK_ON;
    logic               BORDER_ON;
    logic               HS_OUT;
    logic               VS_OUT;
`ifdef GRID_LINE_EN
    logic               GRID_ON;
`endif

    modport master (
        output PIX_X, PIX_Y, VIDEO_ON, HS_IN, VS_IN,
        output WE, W_COL, W_ROW, W_OCC, W_COLOR, CLR,
        input  BUSY, COLOR, BLOCK_ON, BORDER_ON, HS_OUT, VS_OUT
`ifdef GRID_LINE_EN
        , input GRID_ON
`endif
    );

    modport slave (
        input  PIX_X, PIX_Y, VIDEO_ON, HS_IN, VS_IN,
        input  WE, W_COL, W_ROW, W_OCC, W_COLOR, CLR,
        output BUSY, COLOR, BLOCK_ON, BORDER_ON, HS_OUT, VS_OUT
`ifdef GRID_LINE_EN
        , output GRID_ON
`endif
    );
endinterface

// File: rtl/block_cell_fetch.sv
// Maps the VGA pixel onto the playfield grid and fetches that cell's colour (2-cycle latency).
// Optional macro GRID_LINE_EN adds a GRID_ON cell-outline output.
module block_cell_fetch #(
    parameter int ORG_X     = 240,
    parameter int ORG_Y     = 80,
    parameter int BLK_SHIFT = 4,
    parameter int COLS      = 10,
    parameter int ROWS      = 20,
    parameter int COLOR_W   = 3,
    parameter int BORDER_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    block_cell_fetch_if.slave bus
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    localparam logic signed [10:0] ORG_X_C   = 11'(ORG_X);
    localparam logic signed [10:0] ORG_Y_C   = 11'(ORG_Y);
    localparam logic signed [10:0] ZERO_C    = 11'sd0;
    localparam logic signed [10:0] BOARD_W_C = 11'(COLS << BLK_SHIFT);
    localparam logic signed [10:0] BOARD_H_C = 11'(ROWS << BLK_SHIFT);
    localparam logic signed [10:0] FRAME_LO  = 11'(-BORDER_W);
    localparam logic signed [10:0] FRAME_XHI = 11'((COLS << BLK_SHIFT) + BORDER_W);
    localparam logic signed [10:0] FRAME_YHI = 11'((ROWS << BLK_SHIFT) + BORDER_W);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    logic signed [10:0] dx_s;
    logic signed [10:0] dy_s;
    logic               in_board_s;
    logic               in_rect_s;
    logic               in_frame_s;

    logic               vid1_r;
    logic               hs1_r;
    logic               vs1_r;
    logic               in_board1_r;
    logic               in_frame1_r;
    logic [3:0]         col1_r;
    logic [4:0]         row1_r;

    logic [COLOR_W:0]   cell_mem_r [CELLS];
    logic [AW-1:0]      rd_addr_s;
    logic [COLOR_W:0]   cell_rd_s;
    logic               blk_s;

    logic [COLOR_W-1:0] color_r;
    logic               block_on_r;
    logic               border_on_r;
    logic               hs_out_r;
    logic               vs_out_r;

    state_t             state_r;
    logic [AW-1:0]      cnt_r;
    logic               busy_r;
    logic               sweep_wr_s;
    logic               wr_ok_s;
    logic [AW-1:0]      wr_addr_s;

    assign dx_s = signed'({1'b0, bus.PIX_X}) - ORG_X_C;
    assign dy_s = signed'({1'b0, bus.PIX_Y}) - ORG_Y_C;

    assign in_board_s = (dx_s >= ZERO_C) && (dx_s < BOARD_W_C) &&
                        (dy_s >= ZERO_C) && (dy_s < BOARD_H_C);
    assign in_rect_s  = (dx_s >= FRAME_LO) && (dx_s < FRAME_XHI) &&
                        (dy_s >= FRAME_LO) && (dy_s < FRAME_YHI);
    assign in_frame_s = in_rect_s && !in_board_s;

    // Stage 1: board-relative coordinates, region flags and delayed sync
    always_ff @(posedge CLK) begin
        if (RST) begin
            vid1_r      <= 1'b0;
            hs1_r       <= 1'b0;
            vs1_r       <= 1'b0;
            in_board1_r <= 1'b0;
            in_frame1_r <= 1'b0;
            col1_r      <= 4'd0;
            row1_r      <= 5'd0;
        end else begin
            vid1_r      <= bus.VIDEO_ON;
            hs1_r       <= bus.HS_IN;
            vs1_r       <= bus.VS_IN;
            in_board1_r <= in_board_s;
            in_frame1_r <= in_frame_s;
            col1_r      <= dx_s[BLK_SHIFT +: 4];
            row1_r      <= dy_s[BLK_SHIFT +: 5];
        end
    end

    // Read address is forced to 0 off-board so it always stays inside the store
    always_comb begin
        rd_addr_s = '0;
        if (in_board1_r) begin
            rd_addr_s = AW'(32'(row1_r) * COLS + 32'(col1_r));
        end else begin
            rd_addr_s = '0;
        end
    end

    assign cell_rd_s = cell_mem_r[rd_addr_s];
    assign blk_s     = vid1_r & in_board1_r & cell_rd_s[COLOR_W];

    // Stage 2: cell lookup result and frame flag, all registered
    always_ff @(posedge CLK) begin
        if (RST) begin
            color_r     <= '0;
            block_on_r  <= 1'b0;
            border_on_r <= 1'b0;
            hs_out_r    <= 1'b0;
            vs_out_r    <= 1'b0;
        end else begin
            color_r     <= blk_s ? cell_rd_s[COLOR_W-1:0] : '0;
            block_on_r  <= blk_s;
            border_on_r <= vid1_r & in_frame1_r;
            hs_out_r    <= hs1_r;
            vs_out_r    <= vs1_r;
        end
    end

`ifdef GRID_LINE_EN
    logic grid_edge1_r;
    logic grid_on_r;

    // Grid: outline pixels of empty on-board cells, same latency as BLOCK_ON
    always_ff @(posedge CLK) begin
        if (RST) begin
            grid_edge1_r <= 1'b0;
            grid_on_r    <= 1'b0;
        end else begin
            grid_edge1_r <= (dx_s[BLK_SHIFT-1:0] == '0) || (dy_s[BLK_SHIFT-1:0] == '0);
            grid_on_r    <= vid1_r & in_board1_r & ~cell_rd_s[COLOR_W] & grid_edge1_r;
        end
    end

    assign bus.GRID_ON = grid_on_r;
`endif

    // Game-logic writes are dropped while sweeping or when the cell is off the grid
    always_comb begin
        wr_ok_s   = 1'b0;
        wr_addr_s = '0;
        if (bus.WE && !busy_r && (32'(bus.W_COL) < COLS) && (32'(bus.W_ROW) < ROWS)) begin
            wr_ok_s   = 1'b1;
            wr_addr_s = AW'(32'(bus.W_ROW) * COLS + 32'(bus.W_COL));
        end else begin
            wr_ok_s   = 1'b0;
            wr_addr_s = '0;
        end
    end

    // A reset landing mid-sweep must leave the current counter cell untouched
    assign sweep_wr_s = (state_r == ST_SWEEP) && !RST;

    // Cell store: deliberately not reset, a CLR sweep initialises it
    always_ff @(posedge CLK) begin
        if (sweep_wr_s) begin
            cell_mem_r[cnt_r] <= '0;
        end else if (wr_ok_s) begin
            cell_mem_r[wr_addr_s] <= {bus.W_OCC, bus.W_COLOR};
        end
    end

    // Clear FSM: one cell per cycle, BUSY high for exactly CELLS cycles
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (bus.CLR) begin
                        state_r <= ST_SWEEP;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (cnt_r == AW'(CELLS - 1)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= ST_SWEEP;
                        busy_r  <= 1'b1;
                        cnt_r   <= cnt_r + AW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign bus.BUSY      = busy_r;
    assign bus.COLOR     = color_r;
    assign bus.BLOCK_ON  = block_on_r;
    assign bus.BORDER_ON = border_on_r;
    assign bus.HS_OUT    = hs_out_r;
    assign bus.VS_OUT    = vs_out_r;
endmodule

// File: tb/tb_block_cell_fetch.sv
// Scoreboard bench for block_cell_fetch: stimulus queues expected outputs due two cycles later,
// a negedge monitor pops and compares them.
module tb_block_cell_fetch;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    block_cell_fetch_if #(.COLOR_W(3)) bus ();

    block_cell_fetch dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        int         due;
        logic [6:0] exp;
        string      tag;
    } sb_t;

    sb_t sb[$];

    // Monitor: compare each queued expectation on the negedge it falls due
    initial begin
        sb_t        e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e   = sb.pop_front();
                got = {bus.BLOCK_ON, bus.COLOR, bus.BORDER_ON, bus.HS_OUT, bus.VS_OUT};
                checks++;
                if (e.due != cyc || got !== e.exp) begin
                    errors++;
                    $display("FAIL %s got {blk,col,brd,hs,vs}=%b required=%b (cyc %0d due %0d)",
                             e.tag, got, e.exp, cyc, e.due);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.PIX_X    = 10'd0;
        bus.PIX_Y    = 10'd0;
        bus.VIDEO_ON = 1'b0;
        bus.HS_IN    = 1'b0;
        bus.VS_IN    = 1'b0;
        bus.WE       = 1'b0;
        bus.W_COL    = 4'd0;
        bus.W_ROW    = 5'd0;
        bus.W_OCC    = 1'b0;
        bus.W_COLOR  = 3'd0;
        bus.CLR      = 1'b0;
    endtask

    task automatic push(input string tag, input logic [6:0] exp);
        sb_t e;
        e.due = cyc + 2;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input string tag, input int x, input int y, input logic vid,
                        input logic hs, input logic vs,
                        input logic blk, input logic [2:0] col, input logic brd);
        @(negedge clk);
        drive_idle();
        bus.PIX_X    = 10'(x);
        bus.PIX_Y    = 10'(y);
        bus.VIDEO_ON = vid;
        bus.HS_IN    = hs;
        bus.VS_IN    = vs;
        push(tag, {blk, col, brd, hs, vs});
    endtask

    task automatic write(input int c, input int r, input logic occ, input logic [2:0] color);
        @(negedge clk);
        drive_idle();
        bus.WE      = 1'b1;
        bus.W_COL   = 4'(c);
        bus.W_ROW   = 5'(r);
        bus.W_OCC   = occ;
        bus.W_COLOR = color;
        push("wr_idle", 7'b0);
    endtask

    // Runs one CLR sweep; rst/WE/CLR can be injected at a given BUSY-cycle index
    task automatic sweep(input int rst_at, input int we_at, input int clr_at, output int nbusy);
        @(negedge clk);
        drive_idle();
        bus.CLR = 1'b1;
        @(negedge clk);
        bus.CLR = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 400; k++) begin
            if (!bus.BUSY) break;
            nbusy++;
            bus.WE      = (k == we_at);
            bus.W_COL   = 4'd0;
            bus.W_ROW   = 5'd0;
            bus.W_OCC   = 1'b1;
            bus.W_COLOR = 3'd7;
            bus.CLR     = (k == clr_at);
            rst         = (k == rst_at);
            @(negedge clk);
        end
        drive_idle();
        rst = 1'b0;
    endtask

    function automatic int cx(input int i);
        return 240 + (i % 10) * 16 + 8;
    endfunction

    function automatic int cy(input int i);
        return 80 + (i / 10) * 16 + 8;
    endfunction

    function automatic logic [2:0] fill_col(input int i);
        return 3'((i % 7) + 1);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        drive_idle();
        bus.HS_IN = 1'b1;
        bus.VS_IN = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {26'd0, bus.COLOR, bus.BLOCK_ON, bus.BORDER_ON, bus.HS_OUT, bus.VS_OUT, bus.BUSY}, 32'd0);
        rst = 1'b0;
        drive_idle();

        sweep(-1, -1, -1, n);
        check("powerup_clear_len", n, 200);

        write(3, 5, 1'b1, 3'd5);
        step("cell_3_5",      295, 162, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        step("video_off",     295, 162, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step("frame_left",    238, 200, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
        step("frame_left_in", 236, 200, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
        step("outside_left",  235, 200, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step("frame_corner",  239,  79, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        step("outside_corner",235,  75, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        write(9, 0, 1'b1, 3'd3);
        step("last_col",      399,  80, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        step("right_frame",   400,  80, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        step("right_frame_e", 403,  80, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        step("right_outside", 404,  80, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        write(0, 19, 1'b1, 3'd6);
        step("last_row",      240, 399, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
        step("bottom_frame",  240, 400, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

        write(10, 0, 1'b1, 3'd7);
        write(0, 20, 1'b1, 3'd7);
        step("oob_write_col", cx(10), cy(10), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        write(4, 4, 1'b0, 3'd7);
        step("empty_cell",    cx(44), cy(44), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        step("collide_old",   295, 162, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        write(3, 5, 1'b1, 3'd2);
        step("collide_new",   295, 162, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);

        step("sync_10", 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step("sync_01", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        step("sync_11", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        step("sync_00", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        for (int i = 0; i < 200; i++) write(i % 10, i / 10, 1'b1, fill_col(i));
        step("fill_probe", cx(123), cy(123), 1'b1, 1'b0, 1'b0, 1'b1, fill_col(123), 1'b0);
        sweep(-1, 100, 150, n);
        check("clear_len_we_clr_ignored", n, 200);
        for (int i = 0; i < 200; i++)
            step("after_clear", cx(i), cy(i), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        for (int i = 0; i < 200; i++) write(i % 10, i / 10, 1'b1, fill_col(i));
        repeat (4) @(negedge clk);
        sweep(50, -1, -1, n);
        check("rst_mid_sweep_busy_len", n, 51);
        for (int i = 0; i < 200; i++) begin
            if (i < 50)
                step("rst_cleared", cx(i), cy(i), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
            else
                step("rst_kept", cx(i), cy(i), 1'b1, 1'b0, 1'b0, 1'b1, fill_col(i), 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
